// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type and line-level constants
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, pointers carry an extra wrap bit for full/empty
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en && !full) wp <= wp + 1'b1;
      if (rd_en && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed 8N1 UART transmitter draining frames back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_n,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Overflow,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  tx_state_e state, state_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [UART_DATA_BITS-1:0] shift, rd_data;
  logic full, empty, pop, bit_end, last_bit, line_d;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_BITS)) u_fifo (
    .clk(i_Clock), .rst_n(i_Rst_n), .wr_en(i_Tx_DV), .wr_data(i_Tx_Byte), .rd_en(pop),
    .rd_data(rd_data), .full(full), .empty(empty), .count(o_Fifo_Count)
  );
  assign o_Tx_Ready = !full;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_end && idx == IW'(UART_DATA_BITS - 1);
  always_comb begin
    state_d = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_d = empty ? IDLE : START;
      end
      START: state_d = bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA: state_d = last_bit ? PARITY : DATA;
`else
      DATA: state_d = last_bit ? STOP : DATA;
`endif
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP: if (bit_end) begin
        pop = !empty;
        state_d = empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end
  // the line is registered one cycle behind the state, so it never glitches
  always_comb
    line_d = state == START ? START_BIT : state == DATA ? shift[idx] :
             state == PARITY ? ^shift : state == STOP ? STOP_BIT : IDLE_LEVEL;
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_Tx_Serial <= IDLE_LEVEL;
      o_Tx_Active <= 1'b0;
      o_Tx_Done <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      idx <= (state == DATA && bit_end) ? idx + 1'b1 : idx;
      if (pop) shift <= rd_data;
      o_Tx_Serial <= line_d;
      o_Tx_Active <= state != IDLE;
      o_Tx_Done <= state == STOP && bit_end;
      o_Overflow <= i_Tx_DV && full;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: frame-level reference model plus a line-sampling receiver scoreboard
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  typedef struct {
    logic [7:0] b;
    int t;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
  logic [7:0] din = 8'h00;
  logic ready, ovf, active, serial, done;
  logic [2:0] count;
  int total = 0, bad = 0, edge_n = 0, end_e = 0;
  logic [7:0] mq[$];
  exp_t exp_q[$];
  bit busy = 0, acc, pop_now, was_busy, e_ovf, e_done;
  logic [7:0] tmp;
  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(din), .o_Tx_Ready(ready),
    .o_Fifo_Count(count), .o_Overflow(ovf), .o_Tx_Active(active), .o_Tx_Serial(serial), .o_Tx_Done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask
  // model: each popped byte owns the line for FRAME cycles starting one edge after its pop
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (!rst_n) continue;
    was_busy = busy;
    acc = dv && mq.size() < DEPTH;
    e_ovf = dv && !acc;
    e_done = busy && edge_n == end_e;
    pop_now = mq.size() > 0 && (!busy || e_done);
    if (e_done && !pop_now) busy = 0;
    if (pop_now) begin
      tmp = mq.pop_front();
      exp_q.push_back('{b: tmp, t: edge_n + 1});
      busy = 1;
      end_e = edge_n + FRAME;
    end
    if (acc) mq.push_back(din);
    #1;
    if (rst_n) begin
      check("count", count, mq.size());
      check("ready", ready, mq.size() < DEPTH);
      check("overflow", ovf, e_ovf);
      check("done", done, e_done);
      check("active", active, was_busy);
    end
  end
  initial begin : monitor
    exp_t cur;
    logic [10:0] bits;
    bit aborted, have;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && serial === 1'b0) begin
        have = exp_q.size() > 0;
        check("frame_expected", have, 1);
        cur = have ? exp_q.pop_front() : '{b: 8'h00, t: -1};
        if (have) check("frame_start", edge_n, cur.t);
        aborted = 0;
        bits = '0;
        for (int k = 1; k < NBITS; k++) begin
          repeat (CPB) @(posedge clk);
          #1;
          if (!rst_n) begin
            aborted = 1;
            break;
          end
          bits[k] = serial;
        end
        if (!aborted && have) begin
          check("data", bits[8:1], cur.b);
`ifdef UART_TX_PARITY_EN
          check("parity", bits[9], ^cur.b);
`endif
          check("stop", bits[NBITS-1], 1);
        end
      end
    end
  end
  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    dv = 1'b1;
    din = b;
  endtask
  task automatic idle1();
    @(negedge clk);
    dv = 1'b0;
  endtask
  task automatic drain();
    int g = 0;
    while ((busy || mq.size() > 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_in_time", g < 3000, 1);
    repeat (2 * CPB) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_ready", ready, 1);
    check("rst_serial", serial, 1);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    wr(8'hA5);
    idle1();
    drain();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    idle1();
    drain();
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    idle1();
    drain();
    wr(8'h07);
    idle1();
    drain();
    wr(8'h03);
    idle1();
    drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      dv = (i % 200 < 150) && ($urandom_range(0, 7) == 0);
      din = 8'($urandom);
    end
    idle1();
    drain();
    wr(8'hFF);
    idle1();
    repeat (18) @(negedge clk);
    check("mid_serial_high", serial, 1);
    check("mid_active", active, 1);
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    busy = 0;
    #1;
    check("abort_serial", serial, 1);
    check("abort_active", active, 0);
    check("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_serial", serial, 1);
    check("post_rst_count", count, 0);
    check("leftover_frames", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
